cnn_layer_accel_axi_mem_slave: RTL
==================================

# cnn_layer_accel_axi_mem_slave

AXI responder that serves the accelerator's AXI master port from an internal 64-bit-wide memory. It answers the write address, write data, write response, read address and read data channels that the accelerator's AXI bridge drives. It stands in for DDR in block- and system-level simulation, and doubles as an on-chip scratch memory in FPGA builds. The read side and the write side run independently, and each has one burst outstanding at a time.

## Interface
- C_MEM_DEPTH_LOG2, 12, log2 of memory depth in 64-bit words (default 4096 words = 32 KiB).
- C_INIT_ZERO, 1, if 1 the memory is zero-initialised at elaboration; reset never clears the memory.

Ports:
- clk  in  1  clock (already decided)
- rst  in  1  synchronous, active-high reset (already decided)
- axi_awready out 1 / axi_awid in 4 / axi_awaddr in 29 / axi_awlen in 8 / axi_awsize in 3 / axi_awburst in 2 / axi_awcache in 4 (ignored) / axi_awvalid in 1  — write address channel
- axi_wready out 1 / axi_wdata in 64 / axi_wstrb in 8 / axi_wlast in 1 / axi_wvalid in 1  — write data channel
- axi_bid out 4 / axi_bresp out 2 / axi_bvalid out 1 / axi_bready in 1  — write response channel
- axi_arready out 1 / axi_arid in 4 / axi_araddr in 29 / axi_arlen in 8 / axi_arsize in 3 / axi_arburst in 2 / axi_arcache in 4 (ignored) / axi_arvalid in 1  — read address channel
- axi_rid out 4 / axi_rresp out 2 / axi_rvalid out 1 / axi_rdata out 64 / axi_rlast out 1 / axi_rready in 1  — read data channel

## Operation
- Word index = addr[C_MEM_DEPTH_LOG2+2:3]; addr[2:0] is ignored.
- Beat count = len+1, giving 1..256 beats per burst. Beat counters are 8 bits.
- Burst address increments by one word per beat and wraps modulo the memory depth.
- Response codes are latched per burst at the address handshake:
  - DECERR (2'b11) when any addr bit above index C_MEM_DEPTH_LOG2+2 is nonzero.
  - Otherwise SLVERR (2'b10) when size != 3 or burst != 2'b01. The burst is still executed as a 64-bit INCR burst.
  - Otherwise OKAY (2'b00).
- DECERR write bursts do not modify memory. DECERR read bursts return rdata = 0.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready = 1. On the AW handshake, capture id, start index, len and resp; go to W_DATA.
  - W_DATA: wready = 1. Each W handshake writes the bytes enabled by wstrb (byte lane k = wdata[8k+7:8k]), then advances the index and beat count.
  - On the beat numbered len, go to W_RESP.
  - A wlast mismatch upgrades an OKAY response to SLVERR. A mismatch is wlast = 1 before beat len, or wlast = 0 on beat len.
  - The burst always consumes exactly len+1 beats.
  - W_RESP: bvalid = 1 with captured bid and bresp. On bready go to W_IDLE.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: arready = 1. On the AR handshake, capture id, index, len and resp; go to R_FETCH.
  - R_FETCH: perform a synchronous memory read of the start word; go to R_DATA.
  - R_DATA: rvalid = 1, rid = captured id, rresp = captured resp, rlast = 1 only on beat len.
  - The memory read address is next-index when an R handshake occurs in the current cycle, otherwise the current index. This sustains one beat per cycle while rready = 1 and holds rdata stable under backpressure.
  - After the rlast handshake, go to R_IDLE.
- Same-cycle read and write to the same word: the read returns the old data.
- Only one burst per direction is in flight. There is no ID reordering and no interleaving.

## Timing
- During rst and on the cycle it is sampled, all outputs are 0: awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp and rdata.
- First cycle after rst deasserts: awready = arready = 1.
- AW handshake at cycle T gives wready = 1 at T+1. awready = 0 from T+1 until the B handshake.
- Final W beat at T gives wready = 0 and bvalid = 1 at T+1.
- B handshake at T gives awready = 1 at T+1. Write turnaround is at minimum 1 idle cycle.
- AR handshake at T gives rvalid = 1 with beat 0 at T+2. Beat n appears at T+2+n when rready is held high.
- rvalid, rdata, rlast, rid and rresp hold stable while rready = 0.
- rlast handshake at T gives rvalid = 0 and arready = 1 at T+1.
- bvalid holds until bready.
- Reset mid-burst: both FSMs return to idle on the next edge. No B or R response is issued for the aborted burst. Memory words already written are retained.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single write then read: AW addr 0x100, len 0, W data 0x0123456789ABCDEF, strb 0xFF, wlast 1 -> bresp 0 with bid = awid. Then AR addr 0x100, len 0 -> rdata 0x0123456789ABCDEF, rlast 1, rvalid at AR+2.
- 16-beat INCR write and read at addr 0x200, data = beat index, read with rready toggling every cycle -> data 0..15 in order, rlast only on beat 15, data stable while rready = 0.
- Byte strobes: write 0xFFFFFFFFFFFFFFFF, then 0x0 with strb 0x0F -> readback 0xFFFFFFFF00000000.
- Error codes and wrap-around:
  - awaddr 0x1000_0000 -> bresp 2'b11, memory unchanged.
  - arsize 2 -> rresp 2'b10.
  - wlast missing on beat len -> bresp 2'b10.
  - Default depth, write burst at word 4095 with len 1 -> second beat lands at word 0, bresp 0.
- Reset mid-burst: assert rst after beat 3 of a len-7 read -> rvalid 0 next cycle, arready 1 after reset. A fresh read of words 0..3 written before reset returns the prior data.

Source files
------------

// File: rtl/cnn_layer_accel_axi_mem_slave.sv
// AXI responder backed by a 64-bit-wide internal memory; independent read and
// write FSMs, one INCR burst outstanding per direction.
module cnn_layer_accel_axi_mem_slave #(
    parameter int C_MEM_DEPTH_LOG2 = 12,
    parameter int C_INIT_ZERO      = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        axi_awready,
    input  logic [3:0]  axi_awid,
    input  logic [28:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic [3:0]  axi_awcache,
    input  logic        axi_awvalid,
    output logic        axi_wready,
    input  logic [63:0] axi_wdata,
    input  logic [7:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic [3:0]  axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic        axi_arready,
    input  logic [3:0]  axi_arid,
    input  logic [28:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic [3:0]  axi_arcache,
    input  logic        axi_arvalid,
    output logic [3:0]  axi_rid,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    output logic [63:0] axi_rdata,
    output logic        axi_rlast,
    input  logic        axi_rready
);

    localparam int          IW         = C_MEM_DEPTH_LOG2;
    localparam int          DEPTH      = 1 << C_MEM_DEPTH_LOG2;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;
    localparam logic [1:0]  RESP_DEC   = 2'b11;
    localparam logic [63:0] MEM_INIT   = (C_INIT_ZERO != 0) ? 64'h0 : {64{1'bx}};

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    // Address bits above the memory window decode to nothing; otherwise only
    // 64-bit INCR is native, anything else is executed as such but flagged.
    function automatic logic [1:0] resp_f(input logic [28:0] addr,
                                          input logic [2:0]  size,
                                          input logic [1:0]  burst);
        logic [28:0] hi_mask;
        hi_mask = ~((29'd1 << (C_MEM_DEPTH_LOG2 + 3)) - 29'd1);
        if ((addr & hi_mask) != 29'd0) begin
            resp_f = RESP_DEC;
        end else if ((size != 3'd3) || (burst != 2'b01)) begin
            resp_f = RESP_SLV;
        end else begin
            resp_f = RESP_OKAY;
        end
    endfunction

    logic [63:0] mem_r [DEPTH] = '{default: MEM_INIT};

    w_state_t    w_state_r;
    logic [IW-1:0] w_idx_r;
    logic [7:0]  w_len_r;
    logic [7:0]  w_beat_r;
    logic        w_decerr_r;

    r_state_t    r_state_r;
    logic [IW-1:0] r_idx_r;
    logic [7:0]  r_len_r;
    logic [7:0]  r_beat_r;
    logic        r_decerr_r;

    logic [1:0]  aw_resp_s;
    logic [1:0]  ar_resp_s;
    logic        w_hs_s;
    logic        w_last_beat_s;
    logic        mem_we_s;
    logic        r_hs_s;
    logic [IW-1:0] rd_idx_s;
    logic        unused_s;

    assign unused_s = ^{axi_awcache, axi_arcache};

    // Handshake decode and read-address selection for the next memory read.
    always_comb begin
        aw_resp_s     = resp_f(axi_awaddr, axi_awsize, axi_awburst);
        ar_resp_s     = resp_f(axi_araddr, axi_arsize, axi_arburst);
        w_hs_s        = (w_state_r == W_DATA) && axi_wvalid && axi_wready;
        w_last_beat_s = (w_beat_r == w_len_r);
        mem_we_s      = w_hs_s && !w_decerr_r && !rst;
        r_hs_s        = (r_state_r == R_DATA) && axi_rvalid && axi_rready;
        if (r_hs_s) begin
            rd_idx_s = r_idx_r + IW'(1);
        end else begin
            rd_idx_s = r_idx_r;
        end
    end

    // Byte-lane memory write; reset deliberately leaves contents intact.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (mem_we_s && axi_wstrb[k]) begin
                mem_r[w_idx_r][8*k +: 8] <= axi_wdata[8*k +: 8];
            end
        end
    end

    // Write FSM: AW capture, data beats, B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r   <= W_IDLE;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bid     <= 4'd0;
            axi_bresp   <= 2'b00;
            w_idx_r     <= '0;
            w_len_r     <= 8'd0;
            w_beat_r    <= 8'd0;
            w_decerr_r  <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    axi_awready <= 1'b1;
                    if (axi_awvalid && axi_awready) begin
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b1;
                        axi_bid     <= axi_awid;
                        axi_bresp   <= aw_resp_s;
                        w_decerr_r  <= (aw_resp_s == RESP_DEC);
                        w_idx_r     <= axi_awaddr[C_MEM_DEPTH_LOG2+2:3];
                        w_len_r     <= axi_awlen;
                        w_beat_r    <= 8'd0;
                        w_state_r   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        // The beat count, not wlast, ends the burst.
                        if ((axi_wlast != w_last_beat_s) && (axi_bresp == RESP_OKAY)) begin
                            axi_bresp <= RESP_SLV;
                        end
                        if (w_last_beat_s) begin
                            axi_wready <= 1'b0;
                            axi_bvalid <= 1'b1;
                            w_state_r  <= W_RESP;
                        end else begin
                            w_idx_r  <= w_idx_r + IW'(1);
                            w_beat_r <= w_beat_r + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bvalid && axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                        w_state_r   <= W_IDLE;
                    end
                end
                default: begin
                    axi_awready <= 1'b0;
                    axi_wready  <= 1'b0;
                    axi_bvalid  <= 1'b0;
                    w_state_r   <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: AR capture, first-word fetch, then one beat per accepted R.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r   <= R_IDLE;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_rid     <= 4'd0;
            axi_rresp   <= 2'b00;
            axi_rdata   <= 64'd0;
            r_idx_r     <= '0;
            r_len_r     <= 8'd0;
            r_beat_r    <= 8'd0;
            r_decerr_r  <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    axi_arready <= 1'b1;
                    if (axi_arvalid && axi_arready) begin
                        axi_arready <= 1'b0;
                        axi_rid     <= axi_arid;
                        axi_rresp   <= ar_resp_s;
                        r_decerr_r  <= (ar_resp_s == RESP_DEC);
                        r_idx_r     <= axi_araddr[C_MEM_DEPTH_LOG2+2:3];
                        r_len_r     <= axi_arlen;
                        r_beat_r    <= 8'd0;
                        r_state_r   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    axi_rdata  <= r_decerr_r ? 64'd0 : mem_r[rd_idx_s];
                    axi_rvalid <= 1'b1;
                    axi_rlast  <= (r_len_r == 8'd0);
                    r_state_r  <= R_DATA;
                end
                R_DATA: begin
                    // rdata only reloads on an accepted beat, so it stays
                    // frozen under backpressure even if the word is rewritten.
                    if (r_hs_s) begin
                        if (axi_rlast) begin
                            axi_rvalid  <= 1'b0;
                            axi_rlast   <= 1'b0;
                            axi_arready <= 1'b1;
                            r_state_r   <= R_IDLE;
                        end else begin
                            r_idx_r   <= rd_idx_s;
                            r_beat_r  <= r_beat_r + 8'd1;
                            axi_rdata <= r_decerr_r ? 64'd0 : mem_r[rd_idx_s];
                            axi_rlast <= ((r_beat_r + 8'd1) == r_len_r);
                        end
                    end
                end
                default: begin
                    axi_arready <= 1'b0;
                    axi_rvalid  <= 1'b0;
                    axi_rlast   <= 1'b0;
                    r_state_r   <= R_IDLE;
                end
            endcase
        end
    end

endmodule
